// File: rtl/i9_7980xe_core.sv
// i9_7980xe_core: main counter preempted by 3 nestable prioritised ISRs with event log and 7-seg display; in: clk rst pro_reset[2:0] in_addr[11:0] changef, out: leds[2:0] SEG[7:0] AN[7:0]
module i9_7980xe_core #(
  parameter int SCAN_BITS = 4,
  parameter int SVC_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pro_reset,
  input  logic [11:0] in_addr,
  input  logic        changef,
  output logic [2:0]  leds,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);
  logic [2:0] s1, s2, pend, isr, isr_c, gmask;
  logic [7:0] rem [3];
  logic [7:0] cnt [3];
  logic [31:0] main, log_rd, v;
  logic [11:0] lp;
  logic [SCAN_BITS-1:0] pre;
  logic [2:0] dig;
  logic [1:0] a, l;
  logic busy, comp, grant;
  logic [3:0] nib;
  logic [7:0] glyph;
  logic [31:0] log_mem [4096] = '{default: '0};

  function automatic logic [1:0] hi(input logic [2:0] x);
    return x[2] ? 2'd2 : x[1] ? 2'd1 : 2'd0;
  endfunction

  always_comb begin
    a = hi(isr);
    busy = |isr;
    comp = busy && rem[a] == 8'd0;
    isr_c = comp ? isr & ~(3'b001 << a) : isr;
    l = hi(pend);
    grant = |pend && (isr_c == 3'b000 || l > hi(isr_c));
    gmask = grant ? 3'b001 << l : 3'b000;
    log_rd = log_mem[in_addr];
    v = changef ? main : log_rd;
    nib = v[{dig, 2'b00} +: 4];
  end

  always_comb begin
    case (nib)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      pend <= '0;
      isr <= '0;
      main <= '0;
      lp <= '0;
      for (int i = 0; i < 3; i++) begin
        rem[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      s1 <= pro_reset;
      s2 <= s1;
      pend <= (pend & ~gmask) | (s1 & ~s2);
      isr <= isr_c | gmask;
      if (!busy) main <= main + 32'd1;
      if (comp) lp <= lp + 12'd1;
      for (int i = 0; i < 3; i++) begin
        rem[i] <= gmask[i] ? 8'(SVC_LEN - 1) : (busy && a == 2'(i) && !comp) ? rem[i] - 8'd1 : rem[i];
        cnt[i] <= cnt[i] + 8'(comp && a == 2'(i));
      end
    end
  end

  // Log RAM is not reset; reset only suppresses the write so aborted services leave no entry.
  always_ff @(posedge clk) begin
    if (!rst && comp) log_mem[lp] <= {6'b0, a, main[23:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      dig <= '0;
      AN <= 8'hFE;
      SEG <= 8'hC0;
    end else begin
      pre <= pre + 1'b1;
      if (&pre) dig <= dig + 3'd1;
      AN <= ~(8'd1 << dig);
      SEG <= glyph;
    end
  end

  assign leds = isr;
endmodule

// File: tb/tb_i9_7980xe_core.sv
// tb_i9_7980xe_core: directed self-checking bench for i9_7980xe_core
module tb_i9_7980xe_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] pro_reset = '0;
  logic [11:0] in_addr = '0;
  logic changef = 1'b1;
  logic [2:0] leds;
  logic [7:0] SEG, AN;
  int checks = 0;
  int errs = 0;

  i9_7980xe_core dut (
    .clk(clk), .rst(rst), .pro_reset(pro_reset), .in_addr(in_addr),
    .changef(changef), .leds(leds), .SEG(SEG), .AN(AN)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pro_reset = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] target);
    for (int i = 0; i < 200 && AN !== target; i++) tick();
    chk("an_reached", {24'd0, AN}, {24'd0, target});
  endtask

  initial begin
    // idle counting and display scan
    do_reset();
    chk("rst_leds", {29'd0, leds}, 32'd0);
    chk("rst_an", {24'd0, AN}, 32'hFE);
    chk("rst_seg", {24'd0, SEG}, 32'hC0);
    chk("rst_main", dut.main, 32'd0);
    tick(16);
    chk("idle_main16", dut.main, 32'd16);
    chk("idle_an16", {24'd0, AN}, 32'hFE);
    chk("idle_seg16", {24'd0, SEG}, 32'h8E);
    tick();
    chk("idle_an17", {24'd0, AN}, 32'hFD);
    chk("idle_seg17", {24'd0, SEG}, 32'hF9);
    tick(983);
    chk("idle_main1000", dut.main, 32'd1000);
    chk("idle_an1000", {24'd0, AN}, 32'hBF);
    chk("idle_leds", {29'd0, leds}, 32'd0);
    // single level-0 service, pin held 100 cycles
    pro_reset = 3'b001;
    tick(2);
    chk("l0_before_grant", {29'd0, leds}, 32'd0);
    tick();
    chk("l0_grant", {29'd0, leds}, 32'd1);
    chk("l0_main_grant", dut.main, 32'd1003);
    tick(63);
    chk("l0_last_cycle", {29'd0, leds}, 32'd1);
    chk("l0_main_frozen", dut.main, 32'd1003);
    tick();
    chk("l0_done", {29'd0, leds}, 32'd0);
    chk("l0_cnt", {24'd0, dut.cnt[0]}, 32'd1);
    chk("l0_log", dut.log_mem[0], 32'h000003EB);
    chk("l0_lp", {20'd0, dut.lp}, 32'd1);
    tick(33);
    pro_reset = 3'b000;
    tick(5);
    chk("l0_held_once", {29'd0, leds}, 32'd0);
    chk("l0_cnt_once", {24'd0, dut.cnt[0]}, 32'd1);
    // level 1 preempts level 0, granted 10 cycles after level 0
    do_reset();
    pro_reset = 3'b001;
    tick(3);
    chk("nest_l0", {29'd0, leds}, 32'd1);
    tick(7);
    pro_reset = 3'b011;
    tick(2);
    chk("nest_wait", {29'd0, leds}, 32'd1);
    tick();
    chk("nest_l1", {29'd0, leds}, 32'd3);
    tick(63);
    chk("nest_l1_last", {29'd0, leds}, 32'd3);
    tick();
    chk("nest_back_l0", {29'd0, leds}, 32'd1);
    chk("nest_log0", dut.log_mem[0], 32'h01000003);
    tick(53);
    chk("nest_l0_last", {29'd0, leds}, 32'd1);
    tick();
    chk("nest_done", {29'd0, leds}, 32'd0);
    chk("nest_log1", dut.log_mem[1], 32'h00000003);
    chk("nest_cnt1", {24'd0, dut.cnt[1]}, 32'd1);
    chk("nest_lp", {20'd0, dut.lp}, 32'd2);
    // all three at once: 2, 1, 0 back-to-back
    do_reset();
    pro_reset = 3'b111;
    tick(3);
    chk("all_l2", {29'd0, leds}, 32'd4);
    tick(63);
    chk("all_l2_last", {29'd0, leds}, 32'd4);
    tick();
    chk("all_l1", {29'd0, leds}, 32'd2);
    tick(64);
    chk("all_l0", {29'd0, leds}, 32'd1);
    tick(64);
    chk("all_done", {29'd0, leds}, 32'd0);
    chk("all_log0", dut.log_mem[0], 32'h02000003);
    chk("all_log1", dut.log_mem[1], 32'h01000003);
    chk("all_log2", dut.log_mem[2], 32'h00000003);
    pro_reset = 3'b000;
    // two level-0 pulses during level 2 coalesce
    do_reset();
    pro_reset = 3'b100;
    tick(3);
    pro_reset = 3'b101;
    tick(3);
    pro_reset = 3'b100;
    tick(3);
    pro_reset = 3'b101;
    tick(3);
    pro_reset = 3'b100;
    chk("coal_l2", {29'd0, leds}, 32'd4);
    tick(54);
    chk("coal_l2_last", {29'd0, leds}, 32'd4);
    tick();
    chk("coal_l0", {29'd0, leds}, 32'd1);
    tick(63);
    chk("coal_l0_last", {29'd0, leds}, 32'd1);
    tick();
    chk("coal_done", {29'd0, leds}, 32'd0);
    tick(10);
    chk("coal_idle", {29'd0, leds}, 32'd0);
    chk("coal_cnt0", {24'd0, dut.cnt[0]}, 32'd1);
    chk("coal_lp", {20'd0, dut.lp}, 32'd2);
    // reset mid-service aborts without logging
    do_reset();
    pro_reset = 3'b001;
    tick(20);
    chk("abort_active", {29'd0, leds}, 32'd1);
    do_reset();
    tick(10);
    chk("abort_leds", {29'd0, leds}, 32'd0);
    chk("abort_cnt0", {24'd0, dut.cnt[0]}, 32'd0);
    chk("abort_lp", {20'd0, dut.lp}, 32'd0);
    chk("abort_main", dut.main, 32'd10);
    chk("abort_log0_kept", dut.log_mem[0], 32'h02000003);
    // display of the event log
    changef = 1'b0;
    in_addr = 12'd0;
    tick();
    wait_an(8'hFE);
    chk("disp_log_d0", {24'd0, SEG}, 32'hB0);
    wait_an(8'hBF);
    chk("disp_log_d6", {24'd0, SEG}, 32'hA4);
    in_addr = 12'd5;
    tick();
    wait_an(8'hFE);
    chk("disp_empty_d0", {24'd0, SEG}, 32'hC0);
    wait_an(8'hBF);
    chk("disp_empty_d6", {24'd0, SEG}, 32'hC0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
